// File: rtl/fp_store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_store_buffer_if
// Description : swc1 store, data-memory write and load-forward signals
//               of the FP store buffer, grouped as one bundle.
// Revision    : 1.0  initial release
// ============================================================================
interface fp_store_buffer_if #(
    parameter int ADDR_W = 8
);
    logic              st_valid;
    logic              st_ready;
    logic [31:0]       st_addr;
    logic [31:0]       st_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       ld_addr;
    logic              ld_hit;
    logic [31:0]       ld_data;

    // Pipeline / memory environment side
    modport master (
        output st_valid, st_addr, st_data, mem_ack, ld_addr,
        input  st_ready, mem_we, mem_addr, mem_wdata, ld_hit, ld_data
    );

    // Store buffer side
    modport slave (
        input  st_valid, st_addr, st_data, mem_ack, ld_addr,
        output st_ready, mem_we, mem_addr, mem_wdata, ld_hit, ld_data
    );
endinterface
`default_nettype wire

// File: rtl/fp_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fp_store_buffer
// Description : In-order swc1 store FIFO draining into data memory.
//               Define STORE_FWD_EN to enable lwc1 forwarding from queued stores.
// Revision    : 1.0  initial release
// ============================================================================
module fp_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    fp_store_buffer_if.slave            bus,
    output logic                        misalign,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  r_word [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_misalign;

    logic w_take;
    logic w_aligned;
    logic w_push;
    logic w_pop;
    logic w_unused_addr;

    // A misaligned store still completes the handshake; it is just not queued.
    assign w_take    = bus.st_valid && bus.st_ready;
    assign w_aligned = (bus.st_addr[1:0] == 2'b00);
    assign w_push    = w_take && w_aligned;
    assign w_pop     = (r_count != '0) && bus.mem_ack;

    assign w_unused_addr = ^{bus.st_addr[31:ADDR_W+2], bus.ld_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_word[i] <= '0;
                r_data[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
        end else begin
            if (w_push) begin
                r_word[r_wr_ptr] <= bus.st_addr[ADDR_W+1:2];
                r_data[r_wr_ptr] <= bus.st_data;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_misalign <= w_take && !w_aligned;
        end
    end

    assign bus.st_ready  = (r_count != c_FULL);
    assign bus.mem_we    = (r_count != '0);
    assign bus.mem_addr  = r_word[r_rd_ptr];
    assign bus.mem_wdata = r_data[r_rd_ptr];
    assign misalign      = r_misalign;
    assign empty         = (r_count == '0);
    assign count         = r_count;

`ifdef STORE_FWD_EN
    logic        w_hit;
    logic [31:0] w_fwd;

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((c_CNT_W'(i) < r_count) &&
                (r_word[r_rd_ptr + c_PTR_W'(i)] == bus.ld_addr[ADDR_W+1:2])) begin
                w_hit = 1'b1;
                w_fwd = r_data[r_rd_ptr + c_PTR_W'(i)];
            end
        end
    end

    assign bus.ld_hit  = w_hit;
    assign bus.ld_data = w_fwd;
`else
    assign bus.ld_hit  = 1'b0;
    assign bus.ld_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_store_buffer
// Description : Directed plus randomized checks of fp_store_buffer against a
//               queue-based reference model and a captured data memory.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fp_store_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    typedef struct {
        logic [7:0]  w;
        logic [31:0] d;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       misalign;
    logic       empty;
    logic [2:0] count;

    int n_vec  = 0;
    int n_fail = 0;

    ent_t        q[$];
    logic        mis_exp = 1'b0;
    logic [31:0] dm_exp [256];
    logic [31:0] dm_act [256];

    fp_store_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    fp_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .misalign (misalign),
        .empty    (empty),
        .count    (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.mem_we && bus.mem_ack)
            dm_act[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance model.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic ack, input logic [31:0] la);
        int          sz;
        logic        acc;
        logic        mis_next;
        logic        hit;
        logic [31:0] fwd;
        @(negedge clk);
        bus.st_valid = v;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.mem_ack  = ack;
        bus.ld_addr  = la;
        #1;
        sz = q.size();
        check("st_ready", {31'd0, bus.st_ready}, {31'd0, sz != DEPTH});
        check("count",    {29'd0, count}, sz);
        check("empty",    {31'd0, empty}, {31'd0, sz == 0});
        check("mem_we",   {31'd0, bus.mem_we}, {31'd0, sz != 0});
        check("misalign", {31'd0, misalign}, {31'd0, mis_exp});
        if (sz != 0) begin
            check("mem_addr",  {24'd0, bus.mem_addr}, {24'd0, q[0].w});
            check("mem_wdata", bus.mem_wdata, q[0].d);
        end
        hit = 1'b0;
        fwd = '0;
`ifdef STORE_FWD_EN
        for (int i = sz - 1; i >= 0; i--) begin
            if (!hit && q[i].w == la[9:2]) begin
                hit = 1'b1;
                fwd = q[i].d;
            end
        end
`endif
        check("ld_hit",  {31'd0, bus.ld_hit}, {31'd0, hit});
        check("ld_data", bus.ld_data, fwd);

        acc      = v && (sz != DEPTH);
        mis_next = acc && (a[1:0] != 2'b00);
        if (sz != 0 && ack) begin
            dm_exp[q[0].w] = q[0].d;
            void'(q.pop_front());
        end
        if (acc && a[1:0] == 2'b00)
            q.push_back('{w: a[9:2], d: d});
        @(posedge clk);
        mis_exp = mis_next;
    endtask

    task automatic idle(input logic ack, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, ack, 32'd0);
    endtask

    // Asynchronous reset asserted between edges, checked before any clock.
    task automatic do_reset();
        @(negedge clk);
        bus.st_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_count",   {29'd0, count}, 32'd0);
        check("rst_mem_we",  {31'd0, bus.mem_we}, 32'd0);
        check("rst_ready",   {31'd0, bus.st_ready}, 32'd1);
        check("rst_empty",   {31'd0, empty}, 32'd1);
        check("rst_mis",     {31'd0, misalign}, 32'd0);
        check("rst_ld_hit",  {31'd0, bus.ld_hit}, 32'd0);
        check("rst_ld_data", bus.ld_data, 32'd0);
        check("rst_maddr",   {24'd0, bus.mem_addr}, 32'd0);
        check("rst_mwdata",  bus.mem_wdata, 32'd0);
        q.delete();
        mis_exp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] la;
        for (int i = 0; i < 256; i++) begin
            dm_exp[i] = '0;
            dm_act[i] = '0;
        end
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.mem_ack  = 1'b0;
        bus.ld_addr  = '0;

        do_reset();

        // Single store, immediate drain
        cycle(1'b1, 32'h0, 32'h3F80_0000, 1'b1, 32'h0);
        idle(1'b1, 2);

        // Fill past full with memory stalled, then release
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 32'h0);
        idle(1'b1, 5);

        // Misaligned store is dropped
        cycle(1'b1, 32'h0000_0006, 32'h1234_5678, 1'b1, 32'h0);
        idle(1'b1, 2);

        // Back-to-back push with continuous drain, pointers wrap
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 32'(i * 4), 32'hD000_0000 + 32'(i), 1'b1, 32'h0);
        idle(1'b1, 2);

        // Forwarding: two stores to the same word, youngest wins
        cycle(1'b1, 32'h8, 32'hAAAA_AAAA, 1'b0, 32'h8);
        cycle(1'b1, 32'h8, 32'hBBBB_BBBB, 1'b0, 32'h8);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h8);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'hC);
        idle(1'b1, 3);

        // Reset with entries pending leaves no stale writes
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h40 + 32'(i * 4), 32'hEEEE_0000 + 32'(i), 1'b0, 32'h0);
        do_reset();
        idle(1'b1, 4);

        // Randomized traffic over a small word window with upper-bit aliasing
        for (int n = 0; n < 400; n++) begin
            ra = $urandom();
            ra[9:6] = 4'd0;
            if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
            la = $urandom();
            la[9:6] = 4'd0;
            cycle(1'($urandom_range(0, 3) != 0), ra, $urandom(),
                  1'($urandom_range(0, 2) != 0), la);
        end
        idle(1'b1, DEPTH + 2);

        for (int i = 0; i < 256; i++)
            check("dmem", dm_act[i], dm_exp[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fp_store_buffer.md
Name: fp_store_buffer

Overview:
- Write-side counterpart of the lwc1 load path: takes swc1 stores (FP register value + effective address) from the MEM stage and writes them into data memory.
- Small in-order FIFO decouples the pipeline from the data memory write port; one store accepted and one drained per cycle max.
- Optional load-forwarding port lets a following lwc1 read store data still queued in the buffer.

Parameters:
- DEPTH, 4, buffer entries (power of 2, >=2)
- ADDR_W, 8, data memory word-index width (dataMem depth = 2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- st_valid  in  1  swc1 store request from MEM stage
- st_ready  out  1  buffer can accept (not full)
- st_addr  in  32  byte effective address (base + offset)
- st_data  in  32  FP register value (e.g. f0)
- mem_we  out  1  data memory write strobe (head entry valid)
- mem_addr  out  ADDR_W  word index = head addr[ADDR_W+1:2]
- mem_wdata  out  32  head entry data
- mem_ack  in  1  memory accepts write this cycle
- ld_addr  in  32  lwc1 byte address (forwarding only)
- ld_hit  out  1  queued store matches ld_addr (forwarding only)
- ld_data  out  32  youngest matching queued data (forwarding only)
- misalign  out  1  registered 1-cycle pulse: store dropped, addr[1:0]!=0
- empty  out  1  no pending stores
- count  out  $clog2(DEPTH)+1  pending entries

Behaviour:
- Reset (async, any time, incl. mid-drain): all entries invalidated, wr/rd pointers 0, count=0, empty=1, st_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, misalign=0, ld_hit=0, ld_data=0.
- Push: st_valid && st_ready && st_addr[1:0]==0 at rising edge -> entry {st_addr[ADDR_W+1:2], st_data} written at wr_ptr, wr_ptr wraps modulo DEPTH.
- Misaligned: st_valid && st_ready && st_addr[1:0]!=0 -> nothing queued, misalign=1 next cycle for one cycle; counts as consumed handshake.
- st_ready = (count != DEPTH), combinational from registered count; no same-cycle full bypass (full + ack still refuses push that cycle).
- Drain: mem_we = !empty; mem_addr/mem_wdata driven from head entry (registered storage, no comb path from st_*). mem_we && mem_ack at edge -> pop, rd_ptr wraps.
- Latency: store accepted at edge N is presented on mem_we in cycle after edge N; with mem_ack tied 1 written at edge N+1.
- Simultaneous push + pop: count unchanged, both pointers advance; valid at any fill level 1..DEPTH-1.
- Ordering strictly FIFO; two stores to same word both written, later overwrites earlier in memory.
- mem_ack while empty ignored.
- Address bits above ADDR_W+1 discarded (memory wraps).

Optional Feature:
- Macro STORE_FWD_EN.
- Defined: ld_hit=1 when any valid entry's word index equals ld_addr[ADDR_W+1:2]; ld_data = youngest matching entry (nearest to wr_ptr); purely combinational over stored entries, ignores same-cycle push; entry popped this cycle still visible until the edge.
- Undefined: ld_hit and ld_data tied 0; ld_addr unused; no compare logic synthesized.

Test Plan:
- Reset, then st_valid=1, st_addr=0x0000_0000, st_data=0x3F80_0000, mem_ack=1 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x3F80_0000; following cycle empty=1; dataMem[0]=0x3F80_0000.
- mem_ack=0, push 5 stores to addrs 0x0,0x4,0x8,0xC,0x10 -> first four accepted, count=4, st_ready=0 on 5th; release ack -> writes appear in order to dataMem[0..3] over 4 cycles.
- Push addr 0x0000_0006 data 0x1234_5678 -> misalign pulses 1 cycle, count stays 0, mem_we never asserted.
- Continuous push every cycle with mem_ack=1 for 10 stores -> count stays 1, pointers wrap past DEPTH, dataMem[0..9] correct.
- STORE_FWD_EN, mem_ack=0: push 0x8<-0xAAAA_AAAA then 0x8<-0xBBBB_BBBB, ld_addr=0x8 -> ld_hit=1, ld_data=0xBBBB_BBBB; ld_addr=0xC -> ld_hit=0.
- Assert rst with 3 entries pending, mem_ack=0 -> immediately count=0, mem_we=0, st_ready=1; release rst, ack=1 -> no stale writes.
